// File: rtl/serial_port_core.sv
// 8051 serial port datapath for UART modes 1 and 3: shifts frames on TXD/RXD
// and returns TI/RI set pulses plus RB8 to the SFR block.
module serial_port_core #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_scon,
    input  logic       i_sbuf_wr,
    input  logic [7:0] i_sbuf_byte,
    input  logic       i_baud_tick,
    input  logic       i_rxd,
    output logic       o_txd,
    output logic [7:0] o_sbuf_rx,
    output logic       o_rb8,
    output logic       o_set_ti,
    output logic       o_set_ri,
    output logic       o_tx_busy
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_BIT9,
        ST_STOP
    } state_e;

    logic scon_sm0_c, scon_mode_ok_c, scon_sm2_c, scon_ren_c, scon_tb8_c, scon_ri_c;
    logic unused_scon;

    assign scon_sm0_c     = i_scon[7];
    assign scon_mode_ok_c = i_scon[6];
    assign scon_sm2_c     = i_scon[5];
    assign scon_ren_c     = i_scon[4];
    assign scon_tb8_c     = i_scon[3];
    assign scon_ri_c      = i_scon[0];
    assign unused_scon    = ^i_scon[2:1];

    // ---------------- transmitter ----------------
    state_e              tx_state_q, tx_state_d;
    logic [TICK_W-1:0]   tx_tick_q, tx_tick_d;
    logic [2:0]          tx_bit_q, tx_bit_d;
    logic [7:0]          tx_shift_q, tx_shift_d;
    logic                tx_tb8_q, tx_tb8_d;
    logic                tx_m3_q, tx_m3_d;
    logic                txd_q, txd_d;
    logic                set_ti_q, set_ti_d;
    logic                tx_busy_q, tx_busy_d;
    logic                tx_bit_end_c;

    assign tx_bit_end_c = i_baud_tick && (tx_tick_q == TICK_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tx_state_q <= ST_IDLE;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_tb8_q   <= 1'b0;
            tx_m3_q    <= 1'b0;
            txd_q      <= 1'b1;
            set_ti_q   <= 1'b0;
            tx_busy_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_tick_q  <= tx_tick_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_tb8_q   <= tx_tb8_d;
            tx_m3_q    <= tx_m3_d;
            txd_q      <= txd_d;
            set_ti_q   <= set_ti_d;
            tx_busy_q  <= tx_busy_d;
        end
    end

    // txd_d carries the level of the bit that starts on the same edge as the state change
    always_comb begin
        tx_state_d = tx_state_q;
        tx_tick_d  = tx_tick_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_tb8_d   = tx_tb8_q;
        tx_m3_d    = tx_m3_q;
        txd_d      = txd_q;
        set_ti_d   = 1'b0;

        if ((tx_state_q != ST_IDLE) && i_baud_tick) begin
            tx_tick_d = tx_bit_end_c ? '0 : tx_tick_q + TICK_W'(1);
        end

        case (tx_state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
                if (i_sbuf_wr && scon_mode_ok_c) begin
                    tx_shift_d = i_sbuf_byte;
                    tx_tb8_d   = scon_tb8_c;
                    tx_m3_d    = scon_sm0_c;
                    tx_tick_d  = '0;
                    tx_bit_d   = '0;
                    txd_d      = 1'b0;
                    tx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (tx_bit_end_c) begin
                    txd_d      = tx_shift_q[0];
                    tx_state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tx_bit_end_c) begin
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    if (tx_bit_q == 3'd7) begin
                        if (tx_m3_q) begin
                            txd_d      = tx_tb8_q;
                            tx_state_d = ST_BIT9;
                        end else begin
                            txd_d      = 1'b1;
                            set_ti_d   = 1'b1;
                            tx_state_d = ST_STOP;
                        end
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                        txd_d    = tx_shift_q[1];
                    end
                end
            end
            ST_BIT9: begin
                if (tx_bit_end_c) begin
                    txd_d      = 1'b1;
                    set_ti_d   = 1'b1;
                    tx_state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tx_bit_end_c) begin
                    txd_d      = 1'b1;
                    tx_state_d = ST_IDLE;
                end
            end
            default: begin
                txd_d      = 1'b1;
                tx_state_d = ST_IDLE;
            end
        endcase

        tx_busy_d = (tx_state_d != ST_IDLE);
    end

    // ---------------- receiver ----------------
    logic [1:0]          rx_sync_q;
    logic                rx_prev_q;
    state_e              rx_state_q, rx_state_d;
    logic [TICK_W-1:0]   rx_tick_q, rx_tick_d;
    logic [2:0]          rx_bit_q, rx_bit_d;
    logic [7:0]          rx_shift_q, rx_shift_d;
    logic                rx_bit9_q, rx_bit9_d;
    logic                rx_m3_q, rx_m3_d;
    logic [7:0]          sbuf_rx_q, sbuf_rx_d;
    logic                rb8_q, rb8_d;
    logic                set_ri_q, set_ri_d;
    logic                rxd_s_c, rx_fall_c, rx_sample_c, rx_bit_end_c, rx_x_c;

    assign rxd_s_c      = rx_sync_q[1];
    assign rx_fall_c    = rx_prev_q && !rxd_s_c;
    assign rx_sample_c  = i_baud_tick && (rx_tick_q == TICK_MID);
    assign rx_bit_end_c = i_baud_tick && (rx_tick_q == TICK_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_sync_q  <= 2'b11;
            rx_prev_q  <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_bit9_q  <= 1'b0;
            rx_m3_q    <= 1'b0;
            sbuf_rx_q  <= '0;
            rb8_q      <= 1'b0;
            set_ri_q   <= 1'b0;
        end else begin
            rx_sync_q  <= {rx_sync_q[0], i_rxd};
            rx_prev_q  <= rxd_s_c;
            rx_state_q <= rx_state_d;
            rx_tick_q  <= rx_tick_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_bit9_q  <= rx_bit9_d;
            rx_m3_q    <= rx_m3_d;
            sbuf_rx_q  <= sbuf_rx_d;
            rb8_q      <= rb8_d;
            set_ri_q   <= set_ri_d;
        end
    end

    // Samples mid-bit; the stop state returns to IDLE at its sample so the next start is caught
    always_comb begin
        rx_state_d = rx_state_q;
        rx_tick_d  = rx_tick_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_bit9_d  = rx_bit9_q;
        rx_m3_d    = rx_m3_q;
        sbuf_rx_d  = sbuf_rx_q;
        rb8_d      = rb8_q;
        set_ri_d   = 1'b0;
        rx_x_c     = rx_m3_q ? rx_bit9_q : rxd_s_c;

        if ((rx_state_q != ST_IDLE) && i_baud_tick) begin
            rx_tick_d = rx_bit_end_c ? '0 : rx_tick_q + TICK_W'(1);
        end

        case (rx_state_q)
            ST_IDLE: begin
                if (rx_fall_c) begin
                    rx_tick_d  = '0;
                    rx_bit_d   = '0;
                    rx_m3_d    = scon_sm0_c;
                    rx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (rx_sample_c && rxd_s_c) begin
                    rx_state_d = ST_IDLE;
                end else if (rx_bit_end_c) begin
                    rx_state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_sample_c) begin
                    rx_shift_d = {rxd_s_c, rx_shift_q[7:1]};
                end
                if (rx_bit_end_c) begin
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = rx_m3_q ? ST_BIT9 : ST_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end
            end
            ST_BIT9: begin
                if (rx_sample_c) begin
                    rx_bit9_d = rxd_s_c;
                end
                if (rx_bit_end_c) begin
                    rx_state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (rx_sample_c) begin
                    if (!scon_ri_c && (!scon_sm2_c || rx_x_c)) begin
                        sbuf_rx_d = rx_shift_q;
                        rb8_d     = rx_x_c;
                        set_ri_d  = 1'b1;
                    end
                    rx_state_d = ST_IDLE;
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase

        if (!scon_ren_c || !scon_mode_ok_c) begin
            rx_state_d = ST_IDLE;
            sbuf_rx_d  = sbuf_rx_q;
            rb8_d      = rb8_q;
            set_ri_d   = 1'b0;
        end
    end

    assign o_txd     = txd_q;
    assign o_sbuf_rx = sbuf_rx_q;
    assign o_rb8     = rb8_q;
    assign o_set_ti  = set_ti_q;
    assign o_set_ri  = set_ri_q;
    assign o_tx_busy = tx_busy_q;

endmodule

// File: tb/tb_serial_port_core.sv
// Directed bench for serial_port_core: TX waveforms, RX acceptance rules,
// async reset and receiver robustness, with hand-computed expectations.
module tb_serial_port_core;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic [7:0] i_scon = 8'h00;
    logic       i_sbuf_wr = 1'b0;
    logic [7:0] i_sbuf_byte = 8'h00;
    logic       i_baud_tick = 1'b0;
    logic       i_rxd = 1'b1;
    logic       o_txd;
    logic [7:0] o_sbuf_rx;
    logic       o_rb8;
    logic       o_set_ti;
    logic       o_set_ri;
    logic       o_tx_busy;

    int n_tests = 0;
    int n_fail  = 0;
    int ti_cnt  = 0;
    int ri_cnt  = 0;
    logic [1:0] div = 2'd0;

    serial_port_core #(.OVERSAMPLE(16)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_scon      (i_scon),
        .i_sbuf_wr   (i_sbuf_wr),
        .i_sbuf_byte (i_sbuf_byte),
        .i_baud_tick (i_baud_tick),
        .i_rxd       (i_rxd),
        .o_txd       (o_txd),
        .o_sbuf_rx   (o_sbuf_rx),
        .o_rb8       (o_rb8),
        .o_set_ti    (o_set_ti),
        .o_set_ri    (o_set_ri),
        .o_tx_busy   (o_tx_busy)
    );

    always #5 i_clk = ~i_clk;

    // One baud tick every 4 clocks, changed on the falling edge
    always @(negedge i_clk) begin
        div = div + 2'd1;
        i_baud_tick = (div == 2'd0);
    end

    always @(posedge i_clk) begin
        if (o_set_ti) ti_cnt <= ti_cnt + 1;
        if (o_set_ri) ri_cnt <= ri_cnt + 1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge i_clk);
            while (!i_baud_tick) @(posedge i_clk);
        end
    endtask

    task automatic sbuf_write(input logic [7:0] d);
        @(negedge i_clk);
        i_sbuf_wr   = 1'b1;
        i_sbuf_byte = d;
        @(negedge i_clk);
        i_sbuf_wr   = 1'b0;
    endtask

    // Samples o_txd mid-bit and checks the TI pulse lands at the start of the stop bit
    task automatic tx_frame(input logic [7:0] scon, input logic [7:0] data, input bit late_wr);
        logic [10:0] exp;
        int n;
        int ti0;
        exp = '0;
        exp[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp[i+1] = data[i];
        if (scon[7]) begin
            exp[9]  = scon[3];
            exp[10] = 1'b1;
            n = 11;
        end else begin
            exp[9] = 1'b1;
            n = 10;
        end
        i_scon = scon;
        ti0 = ti_cnt;
        sbuf_write(data);
        wait_ticks(8);
        #1;
        for (int b = 0; b < n; b++) begin
            if (b > 0) begin
                wait_ticks(16);
                #1;
            end
            check($sformatf("txd_bit%0d", b), 32'(o_txd), 32'(exp[b]));
            if (b == n - 2) check("ti_before_stop", 32'(ti_cnt - ti0), 0);
            if (b == n - 1) begin
                check("ti_at_stop", 32'(ti_cnt - ti0), 1);
                check("busy_in_stop", 32'(o_tx_busy), 1);
            end
            if (late_wr && b == 3) sbuf_write(8'hFF);
        end
        wait_ticks(8);
        #1;
        check("busy_after_frame", 32'(o_tx_busy), 0);
        check("txd_idle_after", 32'(o_txd), 1);
        check("ti_total", 32'(ti_cnt - ti0), 1);
    endtask

    task automatic send_bit(input logic b);
        i_rxd = b;
        wait_ticks(16);
        #1;
    endtask

    task automatic rx_frame(input logic [7:0] data, input bit m3, input logic b9, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        if (m3) send_bit(b9);
        send_bit(stop);
        send_bit(1'b1);
    endtask

    initial begin
        int ri0;
        int ti0;

        #2 i_rst = 1'b1;
        #1;
        check("rst_txd", 32'(o_txd), 1);
        check("rst_sbuf", 32'(o_sbuf_rx), 0);
        check("rst_rb8", 32'(o_rb8), 0);
        check("rst_busy", 32'(o_tx_busy), 0);
        check("rst_ti", 32'(o_set_ti), 0);
        check("rst_ri", 32'(o_set_ri), 0);
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        repeat (4) @(negedge i_clk);

        // Mode 1 TX of 0xA5 with an ignored write mid-frame
        tx_frame(8'h40, 8'hA5, 1'b1);
        // Mode 3 TX with TB8=1
        tx_frame(8'hC8, 8'h00, 1'b0);

        // Unsupported mode ignores the write
        i_scon = 8'h00;
        sbuf_write(8'h33);
        wait_ticks(4);
        #1;
        check("unsup_busy", 32'(o_tx_busy), 0);
        check("unsup_txd", 32'(o_txd), 1);

        // Async reset in the middle of a TX frame
        i_scon = 8'h40;
        sbuf_write(8'h5A);
        wait_ticks(40);
        #3 i_rst = 1'b1;
        #1;
        check("midrst_txd", 32'(o_txd), 1);
        check("midrst_busy", 32'(o_tx_busy), 0);
        check("midrst_ti", 32'(o_set_ti), 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        ti0 = ti_cnt;
        wait_ticks(200);
        #1;
        check("postrst_txd", 32'(o_txd), 1);
        check("postrst_busy", 32'(o_tx_busy), 0);
        check("postrst_ti", 32'(ti_cnt - ti0), 0);

        // Mode 1 RX accept
        i_scon = 8'h50;
        ri0 = ri_cnt;
        rx_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        check("m1_ri", 32'(ri_cnt - ri0), 1);
        check("m1_sbuf", 32'(o_sbuf_rx), 32'h3C);
        check("m1_rb8", 32'(o_rb8), 1);

        // RI already set: frame rejected
        i_scon = 8'h51;
        ri0 = ri_cnt;
        rx_frame(8'hC3, 1'b0, 1'b0, 1'b1);
        check("ri_set_ri", 32'(ri_cnt - ri0), 0);
        check("ri_set_sbuf", 32'(o_sbuf_rx), 32'h3C);

        // Mode 3 multiprocessor filtering
        i_scon = 8'hF0;
        ri0 = ri_cnt;
        rx_frame(8'h55, 1'b1, 1'b0, 1'b1);
        check("mp_rej_ri", 32'(ri_cnt - ri0), 0);
        check("mp_rej_sbuf", 32'(o_sbuf_rx), 32'h3C);
        check("mp_rej_rb8", 32'(o_rb8), 1);
        ri0 = ri_cnt;
        rx_frame(8'h12, 1'b1, 1'b1, 1'b1);
        check("mp_acc_ri", 32'(ri_cnt - ri0), 1);
        check("mp_acc_sbuf", 32'(o_sbuf_rx), 32'h12);
        check("mp_acc_rb8", 32'(o_rb8), 1);

        // Mode 1 with stop bit 0 and SM2=0 is accepted, RB8 takes the stop sample
        i_scon = 8'h50;
        ri0 = ri_cnt;
        rx_frame(8'h81, 1'b0, 1'b0, 1'b0);
        check("stop0_ri", 32'(ri_cnt - ri0), 1);
        check("stop0_rb8", 32'(o_rb8), 0);
        check("stop0_sbuf", 32'(o_sbuf_rx), 32'h81);

        // 4-tick glitch is a false start
        ri0 = ri_cnt;
        i_rxd = 1'b0;
        wait_ticks(4);
        i_rxd = 1'b1;
        wait_ticks(200);
        #1;
        check("glitch_ri", 32'(ri_cnt - ri0), 0);
        check("glitch_sbuf", 32'(o_sbuf_rx), 32'h81);

        // REN dropped after 3 data bits, then a clean frame
        ri0 = ri_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        i_scon = 8'h40;
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        check("ren_drop_ri", 32'(ri_cnt - ri0), 0);
        check("ren_drop_sbuf", 32'(o_sbuf_rx), 32'h81);
        i_scon = 8'h50;
        ri0 = ri_cnt;
        rx_frame(8'h6E, 1'b0, 1'b0, 1'b1);
        check("ren_back_ri", 32'(ri_cnt - ri0), 1);
        check("ren_back_sbuf", 32'(o_sbuf_rx), 32'h6E);
        check("ren_back_rb8", 32'(o_rb8), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_port_core.md
Name: serial_port_core

Overview:
- 8051 serial-port datapath that consumes the SCON byte and the SBUF write strobe from the SFR block.
- Shifts frames out on TXD and in from RXD.
- Returns one-cycle set requests for TI/RI plus the RB8 value, so the SFR block can update SCON.
- Supports UART modes 1 (8-bit) and 3 (9-bit), timed by an external baud tick with oversampling.

Parameters:
- OVERSAMPLE, 16: baud ticks per bit time; even, ≥4.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  asynchronous active-high reset
- i_scon  input  8  current SCON; bit map SM0[7] SM1[6] SM2[5] REN[4] TB8[3] RB8[2] TI[1] RI[0]
- i_sbuf_wr  input  1  one-cycle strobe: CPU wrote SBUF (start transmit)
- i_sbuf_byte  input  8  byte written to SBUF
- i_baud_tick  input  1  one-cycle pulse, OVERSAMPLE per bit time
- i_rxd  input  1  serial input, asynchronous, idle high
- o_txd  output  1  serial output, idle high
- o_sbuf_rx  output  8  receive buffer (SBUF read value)
- o_rb8  output  1  received 9th bit (mode 3) or stop bit (mode 1); valid when o_set_ri pulses
- o_set_ti  output  1  one-cycle pulse: set SCON.TI
- o_set_ri  output  1  one-cycle pulse: set SCON.RI
- o_tx_busy  output  1  transmitter not idle

Behaviour:
- Reset (async, immediate):
  - o_txd=1; o_sbuf_rx=0; o_rb8=0; o_set_ti=0; o_set_ri=0; o_tx_busy=0.
  - Both FSMs go to IDLE; all counters are cleared.
- Mode decode, from {SM0,SM1}:
  - 01 → mode 1: 10-bit frame (start, 8 data LSB first, stop).
  - 11 → mode 3: 11-bit frame (start, 8 data, 9th bit, stop).
  - 00 and 10 are unsupported: i_sbuf_wr is ignored, the receiver stays IDLE, and o_txd=1.
- TX FSM, states IDLE→START→DATA→BIT9→STOP→IDLE:
  - i_sbuf_wr in IDLE with a supported mode latches i_sbuf_byte, TB8 and the mode, then enters START. o_tx_busy=1 from the next cycle.
  - The tick counter is cleared on load, so the first bit lasts exactly OVERSAMPLE ticks from the first tick after load.
  - Each state holds o_txd for OVERSAMPLE ticks. DATA runs 8 bits, LSB first. BIT9 is visited only in mode 3 and drives the latched TB8.
  - o_set_ti pulses for one cycle on entry to STOP, i.e. at the start of the stop bit.
  - After the stop bit's OVERSAMPLE ticks: IDLE, o_tx_busy=0.
  - i_sbuf_wr while busy is ignored; the frame in flight is unaffected.
  - SCON changes mid-frame do not affect the frame in flight (latched values are used).
- RX input conditioning: i_rxd passes through a 2-flop synchronizer. All RX logic uses the synchronized value.
- RX FSM, states IDLE→START→DATA→BIT9→STOP→IDLE:
  - Runs only when REN=1 and the mode is supported. If REN=0 or the mode becomes unsupported in any state, go to IDLE next cycle and discard the partial frame with no pulses.
  - IDLE: a falling edge (synced 1→0) enters START and clears the tick counter.
  - Sample point is tick count OVERSAMPLE/2-1 within each bit, i.e. mid-bit.
  - START: if the mid-bit sample is 1 (false start), return to IDLE. Otherwise continue.
  - DATA: 8 samples shifted in LSB first. BIT9 is visited in mode 3 only.
  - STOP: at the mid-bit sample, evaluate acceptance, then return to IDLE on the same cycle. The receiver is re-armed for the next falling edge within half a bit.
- RX acceptance, evaluated at the stop sample:
  - Accept iff i_scon.RI==0 AND (SM2==0 OR X==1), where X = stop sample in mode 1, 9th bit in mode 3.
  - On accept: o_sbuf_rx ← data; o_rb8 ← X (mode 3: 9th bit; mode 1: stop bit); o_set_ri pulses for one cycle, all on the same edge.
  - On reject: o_sbuf_rx and o_rb8 keep their old values; no pulse.
- TX and RX are independent and run full duplex.
- o_set_ti and o_set_ri may pulse on the same cycle.

Test Plan:
- Reset: assert i_rst asynchronously mid-TX-frame → o_txd=1, o_tx_busy=0, no pulses; after release, idle until the next i_sbuf_wr.
- Mode 1 TX: SCON=0x40, write 0xA5 → o_txd waveform 0,1,0,1,0,0,1,0,1,1, each bit 16 ticks; o_set_ti one pulse at start of stop bit; o_tx_busy low after 160 ticks; a second write at tick 50 is ignored.
- Mode 3 TX with TB8=1 (SCON=0xC8), write 0x00 → 11-bit frame, bit 9 = 1, o_set_ti at start of bit 10.
- Mode 1 RX: SCON=0x50, frame 0x3C with stop=1 → o_set_ri one pulse, o_sbuf_rx=0x3C, o_rb8=1. Same frame with SCON=0x51 (RI set) → no pulse, o_sbuf_rx unchanged.
- Mode 3 multiprocessor: SCON=0xF0 (SM2=1); frame 0x55 with 9th bit 0 → rejected; frame 0x12 with 9th bit 1 → accepted, o_rb8=1, o_sbuf_rx=0x12.
- Robustness:
  - 4-tick low glitch on RXD → false start, no pulse.
  - REN cleared after 3 data bits → RX idle, no pulse; a subsequent full frame with REN=1 is received correctly.
